// File: rtl/charrom_scan_ctrl.sv
// Text-mode scan controller: fetches character codes, issues char-ROM glyph-row reads on a fixed
// 6-phase schedule, serialises 6-pixel cells and interleaves a host readback slot.
module charrom_scan_ctrl #(
    parameter int unsigned COLS   = 64,
    parameter int unsigned CELL_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_ce,
    input  logic                    line_start,
    input  logic [3:0]              glyph_row,
    output logic [$clog2(COLS)-1:0] vram_addr,
    input  logic [7:0]              vram_data,
    output logic [10:0]             rom_ad,
    output logic                    rom_ce,
    output logic                    rom_oce,
    input  logic [CELL_W-1:0]       rom_dout,
    input  logic                    host_req,
    input  logic [10:0]             host_addr,
    output logic                    host_ack,
    output logic [CELL_W-1:0]       host_data,
    output logic                    pix_out,
    output logic                    active
);

    localparam int unsigned AW = $clog2(COLS);
    localparam int unsigned FW = $clog2(COLS + 1);
    localparam logic [FW-1:0] LAST_COL = FW'(COLS);
    localparam logic [2:0] PH_VIDEO = 3'd1;
    localparam logic [2:0] PH_CAPT  = 3'd3;
    localparam logic [2:0] PH_LAST  = 3'd5;

    logic [2:0]        phase_q, phase_d;
    logic [FW-1:0]     fcol_q, fcol_d;
    logic              running_q, running_d;
    logic              active_q, active_d;
    logic [CELL_W-1:0] shift_q, shift_d;
    logic [CELL_W-1:0] hold_q, hold_d;
    logic              host_busy_q, host_busy_d;
    logic              host_ack_q, host_ack_d;
    logic [CELL_W-1:0] host_data_q, host_data_d;
    logic [10:0]       rom_ad_q, rom_ad_d;
    logic [AW-1:0]     vram_addr_q, vram_addr_d;
    logic              fetching;

    // fcol counts one past the last column during the final display cell.
    assign fetching = running_q && (fcol_q < LAST_COL);

    always_comb begin
        phase_d     = phase_q;
        fcol_d      = fcol_q;
        running_d   = running_q;
        active_d    = active_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        host_busy_d = host_busy_q;
        host_ack_d  = 1'b0;
        host_data_d = host_data_q;
        rom_ad_d    = rom_ad_q;
        vram_addr_d = vram_addr_q;
        if (pix_ce) begin
            phase_d = (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
            shift_d = {shift_q[CELL_W-2:0], 1'b0};
            if (line_start) begin
                phase_d     = 3'd0;
                fcol_d      = '0;
                running_d   = 1'b1;
                active_d    = 1'b0;
                shift_d     = '0;
                vram_addr_d = '0;
                host_busy_d = 1'b0;
            end else begin
                case (phase_q)
                    PH_VIDEO: begin
                        if (fetching) rom_ad_d = {vram_data, glyph_row[2:0]};
                    end
                    PH_CAPT: begin
                        if (fetching) hold_d = glyph_row[3] ? '0 : rom_dout;
                        if (host_req && !host_busy_q) begin
                            rom_ad_d    = host_addr;
                            host_busy_d = 1'b1;
                        end
                    end
                    PH_LAST: begin
                        if (host_busy_q) begin
                            host_data_d = rom_dout;
                            host_ack_d  = 1'b1;
                            host_busy_d = 1'b0;
                        end
                        if (running_q) begin
                            if (fcol_q == LAST_COL) begin
                                running_d = 1'b0;
                                active_d  = 1'b0;
                                shift_d   = '0;
                            end else begin
                                shift_d  = hold_q;
                                active_d = 1'b1;
                                fcol_d   = fcol_q + FW'(1);
                                if (fcol_q < LAST_COL - FW'(1)) begin
                                    vram_addr_d = fcol_q[AW-1:0] + AW'(1);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            fcol_q      <= '0;
            running_q   <= 1'b0;
            active_q    <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            host_busy_q <= 1'b0;
            host_ack_q  <= 1'b0;
            host_data_q <= '0;
            rom_ad_q    <= '0;
            vram_addr_q <= '0;
        end else begin
            phase_q     <= phase_d;
            fcol_q      <= fcol_d;
            running_q   <= running_d;
            active_q    <= active_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            host_busy_q <= host_busy_d;
            host_ack_q  <= host_ack_d;
            host_data_q <= host_data_d;
            rom_ad_q    <= rom_ad_d;
            vram_addr_q <= vram_addr_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign rom_ad    = rom_ad_q;
    assign rom_ce    = pix_ce;
    assign rom_oce   = pix_ce;
    assign host_ack  = host_ack_q;
    assign host_data = host_data_q;
    assign pix_out   = shift_q[CELL_W-1];
    assign active    = active_q;

endmodule

// File: tb/tb_charrom_scan_ctrl.sv
// Randomised bench for charrom_scan_ctrl: VRAM/ROM models, a per-cycle behavioural pixel model
// and a host request scoreboard.
module tb_charrom_scan_ctrl;

    localparam int COLS = 64;
    localparam int LAST = 6 + COLS * 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        line_start = 1'b0;
    logic [3:0]  glyph_row = 4'd0;
    logic [5:0]  vram_addr;
    logic [7:0]  vram_data = 8'd0;
    logic [10:0] rom_ad;
    logic        rom_ce, rom_oce;
    logic [5:0]  rom_dout = 6'd0;
    logic        host_req = 1'b0;
    logic [10:0] host_addr = 11'd0;
    logic        host_ack;
    logic [5:0]  host_data;
    logic        pix_out, active;

    charrom_scan_ctrl #(.COLS(COLS), .CELL_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .line_start(line_start),
        .glyph_row(glyph_row), .vram_addr(vram_addr), .vram_data(vram_data),
        .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
        .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
        .host_data(host_data), .pix_out(pix_out), .active(active)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [COLS];
    logic [5:0] rom [2048];

    // Synchronous VRAM read and char ROM whose data follows the presented address by one
    // enabled cycle (two cycles from issue).
    always @(posedge clk) begin
        if (pix_ce) begin
            vram_data <= vram[vram_addr];
            rom_dout  <= rom[rom_ad];
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state, owned by the checker process.
    int         n = 0;
    bit         line_on = 1'b0;
    logic [3:0] line_row = 4'd0;
    int         act_cnt = 0;
    int         since_rst = 0;
    bit         h_out = 1'b0;
    bit         h_done = 1'b0;
    bit         h_relaxed = 1'b0;
    int         h_lat = 0;
    logic [10:0] h_addr = 11'd0;
    logic [5:0] exp_hdata = 6'd0;

    function automatic logic pix_model(input int idx);
        int col, k;
        logic [5:0] g;
        col = (idx - 7) / 6;
        k   = (idx - 7) % 6;
        g   = (line_row >= 4'd8) ? 6'd0 : rom[{vram[col], line_row[2:0]}];
        return g[5-k];
    endfunction

    initial forever begin
        logic exp_act, exp_pix;
        int   exp_va;
        @(negedge clk);
        if (!rst_n) begin
            n = 0; line_on = 1'b0; since_rst = 0; h_lat = 0; h_relaxed = 1'b1;
            exp_hdata = 6'd0;
        end else begin
            exp_act = line_on && n >= 7 && n <= LAST;
            exp_pix = exp_act ? pix_model(n) : 1'b0;
            exp_va  = line_on ? (((n - 1) / 6 > COLS - 1) ? COLS - 1 : (n - 1) / 6) : 0;
            if (host_ack) begin
                if (!h_out) begin
                    chk("host_ack_unexpected", host_ack, 1'b0);
                end else begin
                    exp_hdata = rom[h_addr];
                    if (!h_relaxed) chk("host_latency_le8", 32'(h_lat <= 8), 1);
                    chk("host_ack_not_before_issue", 32'(since_rst >= 6), 1);
                    h_out = 1'b0;
                    h_done = 1'b1;
                end
            end
            chk("pix_out", pix_out, exp_pix);
            chk("active", active, exp_act);
            chk("vram_addr", vram_addr, exp_va);
            chk("rom_ce", rom_ce, pix_ce);
            chk("rom_oce", rom_oce, pix_ce);
            chk("host_data", host_data, exp_hdata);
            if (h_out && h_lat > 40) begin
                chk("host_timeout", h_lat, 40);
                h_out = 1'b0;
                h_done = 1'b1;
            end
            if (!host_req) h_done = 1'b0;
            else if (!h_out && !h_done) begin
                h_out = 1'b1; h_addr = host_addr; h_lat = 0; h_relaxed = 1'b0;
            end
            if (active && pix_ce) act_cnt++;
            if (pix_ce) begin
                since_rst++;
                if (h_out) h_lat++;
                if (line_start) begin
                    n = 1; line_on = 1'b1; line_row = glyph_row; act_cnt = 0;
                    if (h_out) h_relaxed = 1'b1;
                end else if (line_on && n < 1000000) begin
                    n++;
                end
            end
        end
    end

    int mode = 0;
    bit host_rand = 1'b0;
    int cyc = 0;

    task automatic step();
        logic was_en;
        @(posedge clk);
        was_en = pix_ce;
        #1;
        if (was_en) line_start = 1'b0;
        cyc++;
        case (mode)
            0:       pix_ce = 1'b1;
            1:       pix_ce = (cyc % 3 == 0);
            default: pix_ce = 1'($urandom_range(0, 1));
        endcase
        if (host_req && h_done) host_req = 1'b0;
        else if (!host_req && !h_done && host_rand && $urandom_range(0, 29) == 0) begin
            host_req = 1'b1;
            host_addr = 11'($urandom);
        end
    endtask

    task automatic new_line(input logic [3:0] r, input bit rnd);
        int b = 0;
        if (rnd && (!line_on || n > LAST)) begin
            for (int i = 0; i < COLS; i++) vram[i] = 8'($urandom);
        end
        glyph_row = r;
        line_start = 1'b1;
        while (line_start && b < 20) begin step(); b++; end
    endtask

    task automatic wait_line_done();
        int b = 0;
        while (n <= LAST && b < 6000) begin step(); b++; end
        if (n <= LAST) chk("line_done_timeout", n, LAST + 1);
    endtask

    task automatic wait_host_idle();
        int b = 0;
        while ((host_req || h_done) && b < 200) begin step(); b++; end
    endtask

    initial begin
        logic [5:0] exp6;
        int b;
        for (int i = 0; i < 2048; i++) rom[i] = 6'($urandom);
        for (int i = 0; i < COLS; i++) vram[i] = 8'($urandom);
        vram[0] = 8'h41;
        rom[11'h20A] = 6'h11;
        exp6 = 6'h11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_out", pix_out, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_vram_addr", vram_addr, 6'd0);
        chk("rst_rom_ad", rom_ad, 11'd0);
        chk("rst_host_ack", host_ack, 1'b0);
        chk("rst_host_data", host_data, 6'd0);
        chk("rst_rom_ce", rom_ce, 1'b0);
        rst_n = 1'b1;
        step(); step();

        // Code 0x41 on row 2: glyph 0x11 must appear 6 cycles after the line_start edge.
        glyph_row = 4'd2;
        line_start = 1'b1;
        step();
        step(); step();
        chk("lit_rom_ad", rom_ad, 11'h20A);
        repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            chk("lit_pix", pix_out, exp6[5-i]);
            chk("lit_active", active, 1'b1);
            step();
        end
        wait_line_done();
        chk("lit_active_count", act_cnt, 384);

        new_line(4'd9, 1'b1);
        wait_line_done();
        chk("row9_active_count", act_cnt, 384);

        host_rand = 1'b1;
        for (int l = 0; l < 3; l++) begin
            new_line(4'($urandom_range(0, 15)), 1'b1);
            if (l == 1) begin
                repeat (40) step();
                wait_host_idle();
                host_req = 1'b1;
                host_addr = 11'h7F8;
            end
            wait_line_done();
        end

        mode = 1;
        for (int l = 0; l < 2; l++) begin
            new_line(4'($urandom_range(0, 15)), 1'b1);
            wait_line_done();
        end

        mode = 2;
        for (int l = 0; l < 4; l++) begin
            new_line(4'($urandom_range(0, 15)), 1'b1);
            repeat ($urandom_range(60, 500)) step();
        end
        wait_line_done();

        // Abort at column 30 with a host read issued one cycle before the restart.
        mode = 0;
        host_rand = 1'b0;
        wait_host_idle();
        new_line(4'd5, 1'b1);
        repeat (6 + 30 * 6) step();
        b = 0;
        while (!((n - 1) % 6 == 3 && !host_req && !h_done) && b < 50) begin step(); b++; end
        host_req = 1'b1;
        host_addr = 11'($urandom);
        step();
        line_start = 1'b1;
        step();
        wait_line_done();
        wait_host_idle();

        // Asynchronous reset mid-line with a host read outstanding.
        new_line(4'd3, 1'b1);
        repeat (100) step();
        wait_host_idle();
        host_req = 1'b1;
        host_addr = 11'($urandom);
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pix_out", pix_out, 1'b0);
        chk("arst_active", active, 1'b0);
        chk("arst_vram_addr", vram_addr, 6'd0);
        chk("arst_rom_ad", rom_ad, 11'd0);
        chk("arst_host_ack", host_ack, 1'b0);
        chk("arst_host_data", host_data, 6'd0);
        step(); step();
        rst_n = 1'b1;
        b = 0;
        while (h_out && b < 100) begin step(); b++; end
        wait_host_idle();

        new_line(4'($urandom_range(0, 7)), 1'b1);
        wait_line_done();
        wait_host_idle();
        chk("host_drain_done", h_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
